// File: rtl/chan_capture.sv
// chan_capture: per-channel comparator capture.
// Synchronizes the {CH_H, CH_L} comparator pair, decimates by 2^decim,
// packs four 2-bit {H,L} samples per byte (oldest in [7:6]) with a
// one-clock smpl_vld strobe, and raises a one-shot trigger pulse on a
// selectable edge at full clock resolution.
// Optional build macro: GLITCH_FILT_EN adds a 2-sample agreement filter
// after the synchronizer (one extra clock of latency, 1-clock pulses dropped).
// Handshake: smpl_vld is a pure strobe with no ready; smpl is valid in the
// clock where smpl_vld=1 and holds its value until the next strobe.
module chan_capture #(
  parameter int DECIM_W = 4,
  parameter int CNT_W   = 15
) (
  input  logic               smpl_clk,
  input  logic               rst,
  input  logic               CH_H,
  input  logic               CH_L,
  input  logic               en,
  input  logic [DECIM_W-1:0] decim,
  input  logic [1:0]         trig_cfg,
  output logic [7:0]         smpl,
  output logic               smpl_vld,
  output logic               trig
);

  // Synchronizer and edge flops
  logic r_h_s1, r_h_s2, r_h_d;
  logic r_l_s1, r_l_s2, r_l_d;

  // Bits used for packing and edge detection
  logic w_h_cap, w_l_cap;

  // Decimation and packing state
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period_m1;
  logic             w_tick;
  logic [1:0]       r_phase;
  logic [5:0]       r_shift;
  logic [7:0]       r_smpl;
  logic             r_smpl_vld;

  // Trigger state
  logic r_en_d;
  logic r_armed;
  logic r_trig;
  logic w_rise, w_fall, w_hit;

  // Two-flop synchronizer per comparator input, free-running regardless of en
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_h_s1 <= 1'b0;
      r_h_s2 <= 1'b0;
      r_l_s1 <= 1'b0;
      r_l_s2 <= 1'b0;
    end else begin
      r_h_s1 <= CH_H;
      r_h_s2 <= r_h_s1;
      r_l_s1 <= CH_L;
      r_l_s2 <= r_l_s1;
    end
  end

`ifdef GLITCH_FILT_EN
  // Previous synced value: the filtered bit only moves when two
  // consecutive synced samples agree, otherwise it holds (r_x_d).
  logic r_h_p, r_l_p;

  // Capture the previous synchronized sample for the agreement test
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_h_p <= 1'b0;
      r_l_p <= 1'b0;
    end else begin
      r_h_p <= r_h_s2;
      r_l_p <= r_l_s2;
    end
  end

  assign w_h_cap = (r_h_s2 == r_h_p) ? r_h_s2 : r_h_d;
  assign w_l_cap = (r_l_s2 == r_l_p) ? r_l_s2 : r_l_d;
`else
  assign w_h_cap = r_h_s2;
  assign w_l_cap = r_l_s2;
`endif

  // Delayed copy of the captured bits for edge detection (also filter state)
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_h_d <= 1'b0;
      r_l_d <= 1'b0;
    end else begin
      r_h_d <= w_h_cap;
      r_l_d <= w_l_cap;
    end
  end

  // Sample period minus one; decim is used live
  assign w_period_m1 = (CNT_W'(1) << decim) - CNT_W'(1);
  assign w_tick      = en && (r_cnt == w_period_m1);

  // Decimation counter: held at 0 while disabled, wraps at 2^decim-1
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Packing: shift a {H,L} pair per tick, emit a byte every fourth tick
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_phase    <= 2'd0;
      r_shift    <= 6'd0;
      r_smpl     <= 8'h00;
      r_smpl_vld <= 1'b0;
    end else if (!en) begin
      // Disable discards any partial byte; the last full byte stays visible
      r_phase    <= 2'd0;
      r_shift    <= 6'd0;
      r_smpl_vld <= 1'b0;
    end else begin
      r_smpl_vld <= 1'b0;
      if (w_tick) begin
        r_shift <= {r_shift[3:0], w_h_cap, w_l_cap};
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          r_smpl     <= {r_shift, w_h_cap, w_l_cap};
          r_smpl_vld <= 1'b1;
        end
      end
    end
  end

  // Edge selection for the trigger
  assign w_rise = w_h_cap & ~r_h_d;
  assign w_fall = ~w_l_cap & r_l_d;
  assign w_hit  = (trig_cfg[0] & w_rise) | (trig_cfg[1] & w_fall);

  // Arm on en rising, disarm on the firing edge or when disabled
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_en_d  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_en_d <= en;
      if (!en) begin
        r_armed <= 1'b0;
      end else if (!r_en_d) begin
        r_armed <= 1'b1;
      end else if (r_armed && w_hit) begin
        r_armed <= 1'b0;
      end
    end
  end

  // Registered one-shot trigger pulse
  always_ff @(posedge smpl_clk or posedge rst) begin
    if (rst) begin
      r_trig <= 1'b0;
    end else begin
      r_trig <= r_armed & w_hit;
    end
  end

  assign smpl     = r_smpl;
  assign smpl_vld = r_smpl_vld;
  assign trig     = r_trig;

endmodule

// File: tb/tb_chan_capture.sv
// tb_chan_capture: directed, table-driven bench for chan_capture.
// Table rows hold four {H,L} pairs and the hand-computed packed byte;
// hand-written sequences cover reset, decimation, trigger and filter cases.
module tb_chan_capture;

  logic       clk;
  logic       rst;
  logic       ch_h;
  logic       ch_l;
  logic       en;
  logic [3:0] decim;
  logic [1:0] trig_cfg;
  logic [7:0] smpl;
  logic       smpl_vld;
  logic       trig;

  int n_cmp;
  int n_err;

`ifdef GLITCH_FILT_EN
  localparam int TRIG_LAT = 4;
  localparam logic [7:0] RST_BYTE = 8'h01;
`else
  localparam int TRIG_LAT = 3;
  localparam logic [7:0] RST_BYTE = 8'h05;
`endif

  typedef struct {
    logic [7:0] pairs;
    logic [7:0] exp_smpl;
  } vec_t;

  vec_t vecs[5];

  chan_capture #(.DECIM_W(4), .CNT_W(15)) dut (
    .smpl_clk (clk),
    .rst      (rst),
    .CH_H     (ch_h),
    .CH_L     (ch_l),
    .en       (en),
    .decim    (decim),
    .trig_cfg (trig_cfg),
    .smpl     (smpl),
    .smpl_vld (smpl_vld),
    .trig     (trig)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step until smpl_vld, returning the number of edges taken (max on timeout)
  task automatic wait_vld(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < max) begin
      step();
      n++;
      if (smpl_vld) seen = 1'b1;
    end
  endtask

  // Watch trig for a number of edges; report pulse count and first position
  task automatic trig_watch(input int cycles, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (trig) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  // Pulse en low for one clock so the trigger re-arms
  task automatic rearm();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    step();
  endtask

  // Pack one byte at decim=1; each pair is held for two clocks so the
  // optional filter sees it as a stable value
  task automatic run_byte(input logic [7:0] pairs, input logic [7:0] exp, input int idx);
    en = 1'b0;
    {ch_h, ch_l} = pairs[7:6];
    repeat (4) step();
    en = 1'b1;
    {ch_h, ch_l} = pairs[5:4];
    step();
    step();
    {ch_h, ch_l} = pairs[3:2];
    step();
    step();
    {ch_h, ch_l} = pairs[1:0];
    step();
    step();
    step();
    check($sformatf("vec%0d_vld_early", idx), 32'(smpl_vld), 32'd0);
    step();
    check($sformatf("vec%0d_vld", idx), 32'(smpl_vld), 32'd1);
    check($sformatf("vec%0d_smpl", idx), 32'(smpl), 32'(exp));
    en = 1'b0;
    step();
    check($sformatf("vec%0d_vld_off", idx), 32'(smpl_vld), 32'd0);
    check($sformatf("vec%0d_smpl_hold", idx), 32'(smpl), 32'(exp));
  endtask

  initial begin
    int n;
    int cnt;
    int first;
    int vld_seen;

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{8'b11_01_00_10, 8'hD2};
    vecs[1] = '{8'b01_01_01_01, 8'h55};
    vecs[2] = '{8'b10_10_10_10, 8'hAA};
    vecs[3] = '{8'b00_11_00_11, 8'h33};
    vecs[4] = '{8'b11_11_11_11, 8'hFF};

    // Reset state
    rst = 1'b1;
    ch_h = 1'b0;
    ch_l = 1'b0;
    en = 1'b0;
    decim = 4'd0;
    trig_cfg = 2'b00;
    repeat (3) step();
    check("rst_smpl", 32'(smpl), 32'h00);
    check("rst_vld", 32'(smpl_vld), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    rst = 1'b0;
    step();

    // Packing table at decim=1
    decim = 4'd1;
    for (int i = 0; i < 5; i++) begin
      run_byte(vecs[i].pairs, vecs[i].exp_smpl, i);
    end

    // Reset mid-capture discards the partial byte
    decim = 4'd0;
    {ch_h, ch_l} = 2'b01;
    en = 1'b1;
    step();
    step();
    rst = 1'b1;
    #2;
    check("midrst_smpl", 32'(smpl), 32'h00);
    check("midrst_vld", 32'(smpl_vld), 32'd0);
    check("midrst_trig", 32'(trig), 32'd0);
    step();
    rst = 1'b0;
    wait_vld(20, n);
    check("midrst_fresh_ticks", 32'(n), 32'd4);
    check("midrst_byte", 32'(smpl), 32'(RST_BYTE));

    // Decimation by 8 with constant {H,L}=01
    en = 1'b0;
    decim = 4'd3;
    {ch_h, ch_l} = 2'b01;
    repeat (3) step();
    en = 1'b1;
    wait_vld(100, n);
    check("decim3_first", 32'(n), 32'd32);
    wait_vld(100, n);
    check("decim3_period", 32'(n), 32'd32);
    check("decim3_smpl", 32'(smpl), 32'h55);
    en = 1'b0;
    step();
    decim = 4'd0;
    en = 1'b1;
    wait_vld(20, n);
    check("decim0_first", 32'(n), 32'd4);
    wait_vld(20, n);
    check("decim0_period", 32'(n), 32'd4);

    // en falling on the phase-3 tick suppresses the byte
    step();
    step();
    step();
    en = 1'b0;
    step();
    check("en_fall_ph3_vld", 32'(smpl_vld), 32'd0);
    check("en_fall_ph3_hold", 32'(smpl), 32'h55);

    // Rising trigger, one-shot per en assertion
    trig_cfg = 2'b01;
    {ch_h, ch_l} = 2'b00;
    repeat (3) step();
    en = 1'b1;
    step();
    step();
    ch_h = 1'b1;
    trig_watch(8, cnt, first);
    check("rise_lat", 32'(first), 32'(TRIG_LAT));
    check("rise_cnt", 32'(cnt), 32'd1);
    ch_h = 1'b0;
    repeat (4) step();
    ch_h = 1'b1;
    trig_watch(8, cnt, first);
    check("rise_second_none", 32'(cnt), 32'd0);
    rearm();
    ch_h = 1'b0;
    repeat (4) step();
    ch_h = 1'b1;
    trig_watch(8, cnt, first);
    check("rise_rearm_lat", 32'(first), 32'(TRIG_LAT));
    check("rise_rearm_cnt", 32'(cnt), 32'd1);

    // Falling trigger on CH_L
    trig_cfg = 2'b10;
    {ch_h, ch_l} = 2'b01;
    repeat (4) step();
    rearm();
    ch_l = 1'b0;
    trig_watch(8, cnt, first);
    check("fall_lat", 32'(first), 32'(TRIG_LAT));
    check("fall_cnt", 32'(cnt), 32'd1);

    // Either edge: simultaneous edges give a single pulse
    trig_cfg = 2'b11;
    {ch_h, ch_l} = 2'b01;
    repeat (4) step();
    rearm();
    {ch_h, ch_l} = 2'b10;
    trig_watch(8, cnt, first);
    check("either_lat", 32'(first), 32'(TRIG_LAT));
    check("either_cnt", 32'(cnt), 32'd1);

    // Trigger off never fires
    trig_cfg = 2'b00;
    {ch_h, ch_l} = 2'b01;
    repeat (4) step();
    rearm();
    {ch_h, ch_l} = 2'b10;
    trig_watch(8, cnt, first);
    check("off_cnt_a", 32'(cnt), 32'd0);
    {ch_h, ch_l} = 2'b01;
    repeat (4) step();
    {ch_h, ch_l} = 2'b10;
    trig_watch(8, cnt, first);
    check("off_cnt_b", 32'(cnt), 32'd0);

`ifdef GLITCH_FILT_EN
    // One-clock pulse is filtered out of both trigger and capture
    trig_cfg = 2'b01;
    decim = 4'd0;
    {ch_h, ch_l} = 2'b00;
    repeat (4) step();
    rearm();
    ch_h = 1'b1;
    step();
    ch_h = 1'b0;
    cnt = 0;
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (trig) cnt++;
      if (smpl_vld) begin
        vld_seen++;
        check($sformatf("glitch_byte%0d", vld_seen), 32'(smpl), 32'h00);
      end
    end
    check("glitch_trig_cnt", 32'(cnt), 32'd0);
    check("glitch_bytes_seen", 32'(vld_seen), 32'd3);

    // Three-clock pulse passes with one extra clock of latency
    ch_h = 1'b1;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) ch_h = 1'b0;
      if (trig && first == 0) first = i;
    end
    check("filt_pulse_lat", 32'(first), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
